tpic_readback: RTL and testbench
================================

TPIC_READBACK -- requirements
Module: tpic_readback

Interface
REQ-001 Parameter WIDTH, default 432; TPIC chain length in bits (54 bytes).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  system clock (50 MHz); all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle frame request; sampled only in IDLE.
REQ-006 expected  input  WIDTH  image to load into the chain this frame.
REQ-007 tpic_miso  input  1  chain serial output (TPIC SO of last device).
REQ-008 sclk  output  1  chain shift clock, clk/2 during SHIFT.
REQ-009 sout  output  1  chain serial input (TPIC SI), MSB first.
REQ-010 rck  output  1  chain latch strobe.
REQ-011 busy  output  1  high from the cycle after start through the DONE cycle.
REQ-012 done  output  1  one-cycle pulse at frame end.
REQ-013 readback  output  WIDTH  bits captured from tpic_miso in the last frame.
REQ-014 chain_ok  output  1  last checked frame matched the previous frame image.
REQ-015 err_count  output  8  mismatched bits in the last checked frame, saturating at 255.
REQ-016 first_err  output  $clog2(WIDTH)  index of first mismatch in shift order; all-ones if none.

Function
REQ-017 The FSM SHALL have the states IDLE, SHIFT, LATCH and DONE.
REQ-018 IDLE: start=1 SHALL snapshot expected into frame_img, clear the bit counter, err_count and first_err, and go to SHIFT.
REQ-019 SHIFT: each bit i (0..WIDTH-1) SHALL take 2 clk cycles.
  - Phase 0: sclk=0, sout=frame_img[WIDTH-1-i].
  - Phase 1: sclk=1.
REQ-020 On the clk edge that raises sclk, tpic_miso SHALL be sampled into readback[WIDTH-1-i].
REQ-021 When prev_valid=1, each sample SHALL be compared with prev_img[WIDTH-1-i].
  - A mismatch increments err_count (saturating at 255).
  - The first mismatch loads first_err = WIDTH-1-i.
REQ-022 After bit WIDTH-1, phase 1, the FSM SHALL go to LATCH with sclk=0.
REQ-023 LATCH SHALL hold rck=1 for exactly 2 cycles, then go to DONE.
REQ-024 DONE (1 cycle) SHALL:
  - assert done;
  - set chain_ok = (prev_valid && err_count==0);
  - copy frame_img to prev_img;
  - set prev_valid=1;
  - return to IDLE.
REQ-025 Latency: when start is sampled in cycle 0, done SHALL be high in cycle 2*WIDTH+3.
REQ-026 start while busy SHALL be ignored with no queuing.
REQ-027 Changes on expected after the start cycle SHALL NOT affect the current frame.
REQ-028 First frame after reset (prev_valid=0):
  - no comparison is made;
  - err_count stays 0 and first_err stays all-ones;
  - chain_ok is driven 0.
REQ-029 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-030 readback, err_count, first_err and chain_ok SHALL remain stable in IDLE.
REQ-031 sout SHALL be 0 and sclk/rck SHALL be low outside SHIFT and LATCH.

Reset
REQ-032 reset_n=0 SHALL force, asynchronously:
  - state=IDLE;
  - sclk=0, sout=0, rck=0, busy=0, done=0, chain_ok=0, err_count=0;
  - readback=0, first_err=all-ones, prev_valid=0;
  - frame_img=0, prev_img=0.
REQ-033 Reset mid-frame SHALL abort without an rck pulse.
REQ-034 The next frame after a mid-frame reset SHALL be treated as first (REQ-028).

Structure
REQ-035 Shared package mrly_pkg SHALL hold:
  - TPIC_WIDTH=432;
  - the tpic_readback FSM state encodings;
  - ERR_SAT=255.
REQ-036 tpic_readback SHALL be a single module with no sub-module; bit counter, phase bit and mismatch counter SHALL be internal.

Verification
REQ-037 Bench: WIDTH=16; behavioral TPIC model = 16-flop shift register on sclk rise, SO = MSB, latched on rck.
REQ-038 Two frames, expected=16'hA55A then 16'h1234:
  - frame 2 readback=16'hA55A, chain_ok=1, err_count=0, first_err=4'hF;
  - done at cycle 35 after each start.
REQ-039 First frame after reset, expected=16'hFFFF -> chain_ok=0, err_count=0, rck high exactly 2 cycles, model latch=16'hFFFF.
REQ-040 Model SO stuck at 0, frames 16'h00F0 then 16'h0000 -> frame 2 err_count=4, first_err=7, chain_ok=0.
REQ-041 Pulse start in cycles 5 and 20 of a frame; change expected mid-frame -> single frame, model latch equals the start-time snapshot.
REQ-042 reset_n low at cycle 10 of frame 2 -> all outputs at reset values, no rck; next frame gives chain_ok=0 (treated as first).

Source files
------------

// File: rtl/mrly_pkg.sv
// -----------------------------------------------------------------------------
// mrly_pkg
// Shared definitions for the relay-driver TPIC chain logic.
//   TPIC_WIDTH   : default chain length in bits (54 TPIC devices x 8 bits)
//   ERR_SAT      : saturation value of the per-frame mismatch counter
//   tpic_state_e : state encodings of the tpic_readback frame FSM
// -----------------------------------------------------------------------------
package mrly_pkg;

    localparam int         TPIC_WIDTH = 432;
    localparam logic [7:0] ERR_SAT    = 8'd255;

    typedef enum logic [1:0] {
        TPIC_IDLE  = 2'd0,
        TPIC_SHIFT = 2'd1,
        TPIC_LATCH = 2'd2,
        TPIC_DONE  = 2'd3
    } tpic_state_e;

endpackage : mrly_pkg

// File: rtl/tpic_readback.sv
// -----------------------------------------------------------------------------
// tpic_readback
// Shifts one image into a daisy-chained TPIC shift-register string, latches
// it with an rck pulse, and at the same time captures whatever falls out of
// the end of the chain. Because the chain is a pure shift register, the bits
// that come out during frame N are the image loaded in frame N-1, so the
// captured data is checked against the previous frame's image to detect a
// broken or stuck chain.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   one-cycle frame request, only honoured while idle
//   expected   in   [WIDTH] image to load this frame (snapshotted at start)
//   tpic_miso  in   serial output of the last device in the chain
//   sclk       out  chain shift clock, clk/2 while shifting
//   sout       out  chain serial input, MSB of the image first
//   rck        out  chain latch strobe, high for two cycles after shifting
//   busy       out  high from the cycle after start through the done cycle
//   done       out  one-cycle pulse at frame end
//   readback   out  [WIDTH] bits captured from tpic_miso during the last frame
//   chain_ok   out  last frame matched the image of the frame before it
//   err_count  out  [8] mismatched bits in the last frame, saturating
//   first_err  out  [$clog2(WIDTH)] index of first mismatch, all-ones if none
// -----------------------------------------------------------------------------
module tpic_readback
    import mrly_pkg::*;
#(
    parameter int WIDTH = TPIC_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           expected,
    input  logic                       tpic_miso,
    output logic                       sclk,
    output logic                       sout,
    output logic                       rck,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           readback,
    output logic                       chain_ok,
    output logic [7:0]                 err_count,
    output logic [$clog2(WIDTH)-1:0]   first_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // Saturating increment for the mismatch counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        if (value == ERR_SAT) begin
            return value;
        end
        return value + 8'd1;
    endfunction

    tpic_state_e       state;
    tpic_state_e       state_nxt;

    logic [WIDTH-1:0]  frame_img;   // image being shifted this frame
    logic [WIDTH-1:0]  prev_img;    // image shifted in the previous frame
    logic              prev_valid;  // prev_img holds a completed frame
    logic [CW-1:0]     bit_cnt;     // bit number i in shift order
    logic              phase;       // half-bit phase; doubles as the LATCH cycle counter
    logic [CW-1:0]     bit_idx;     // vector index of bit i (MSB first)
    logic              last_bit;
    logic              mismatch;

    assign bit_idx  = LAST_BIT - bit_cnt;
    assign last_bit = (bit_cnt == LAST_BIT);
    assign mismatch = prev_valid && (tpic_miso != prev_img[bit_idx]);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= TPIC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        sclk      = 1'b0;
        sout      = 1'b0;
        rck       = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        unique case (state)
            TPIC_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = TPIC_SHIFT;
                end
            end

            TPIC_SHIFT: begin
                // sout is held for both phases so the chain sees a stable
                // data bit around the rising sclk edge.
                sclk = phase;
                sout = frame_img[bit_idx];
                if (phase && last_bit) begin
                    state_nxt = TPIC_LATCH;
                end
            end

            TPIC_LATCH: begin
                rck = 1'b1;
                if (phase) begin
                    state_nxt = TPIC_DONE;
                end
            end

            TPIC_DONE: begin
                done      = 1'b1;
                state_nxt = TPIC_IDLE;
            end

            default: begin
                state_nxt = TPIC_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Frame datapath: snapshot, bit/phase counting, capture and comparison
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_img  <= '0;
            prev_img   <= '0;
            prev_valid <= 1'b0;
            bit_cnt    <= '0;
            phase      <= 1'b0;
            readback   <= '0;
            chain_ok   <= 1'b0;
            err_count  <= '0;
            first_err  <= '1;
        end else begin
            unique case (state)
                TPIC_IDLE: begin
                    if (start) begin
                        frame_img <= expected;
                        bit_cnt   <= '0;
                        phase     <= 1'b0;
                        err_count <= '0;
                        first_err <= '1;
                    end
                end

                TPIC_SHIFT: begin
                    phase <= ~phase;
                    if (!phase) begin
                        // This edge raises sclk: the chain shifts just after
                        // it, so tpic_miso still shows the pre-shift bit.
                        readback[bit_idx] <= tpic_miso;
                        if (mismatch) begin
                            err_count <= sat_inc(err_count);
                            // err_count never returns to zero within a
                            // frame, so zero marks "no mismatch seen yet".
                            if (err_count == 8'd0) begin
                                first_err <= bit_idx;
                            end
                        end
                    end else if (!last_bit) begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end

                TPIC_LATCH: begin
                    phase <= ~phase;
                end

                TPIC_DONE: begin
                    chain_ok   <= prev_valid && (err_count == 8'd0);
                    prev_img   <= frame_img;
                    prev_valid <= 1'b1;
                end

                default: begin
                    phase <= 1'b0;
                end
            endcase
        end
    end

endmodule : tpic_readback

// File: tb/tb_tpic_readback.sv
// -----------------------------------------------------------------------------
// tb_tpic_readback
// Directed bench for tpic_readback with a 16-bit behavioural TPIC chain:
// a 16-flop shift register clocked on sclk rise, serial out = MSB, copied
// to an output latch on rck rise.
// -----------------------------------------------------------------------------
module tb_tpic_readback;

    localparam int W = 16;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic          start    = 1'b0;
    logic [W-1:0]  expected = '0;
    logic          tpic_miso;
    logic          sclk;
    logic          sout;
    logic          rck;
    logic          busy;
    logic          done;
    logic [W-1:0]  readback;
    logic          chain_ok;
    logic [7:0]    err_count;
    logic [3:0]    first_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    tpic_readback #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .expected  (expected),
        .tpic_miso (tpic_miso),
        .sclk      (sclk),
        .sout      (sout),
        .rck       (rck),
        .busy      (busy),
        .done      (done),
        .readback  (readback),
        .chain_ok  (chain_ok),
        .err_count (err_count),
        .first_err (first_err)
    );

    // Behavioural TPIC chain
    logic [W-1:0] chain_sr    = '0;
    logic [W-1:0] chain_latch = '0;
    logic         stuck_low   = 1'b0;

    always @(posedge sclk) chain_sr <= {chain_sr[W-2:0], sout};
    always @(posedge rck)  chain_latch <= chain_sr;
    assign tpic_miso = stuck_low ? 1'b0 : chain_sr[W-1];

    // Running counts of rck-high cycles and done pulses
    int rck_cycles  = 0;
    int done_pulses = 0;
    always @(negedge clk) begin
        if (rck)  rck_cycles  <= rck_cycles + 1;
        if (done) done_pulses <= done_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Runs one frame; returns the cycle of done (start cycle = 0) and the
    // number of rck-high cycles. Ends at the negedge of the cycle after done.
    task automatic run_frame(input logic [W-1:0] img, output int lat, output int rcks);
        int rck_base;
        @(negedge clk);
        rck_base = rck_cycles;
        start    = 1'b1;
        expected = img;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        rcks = rck_cycles - rck_base;
    endtask

    initial begin
        int lat;
        int rcks;
        int done_base;
        int rck_base;
        int done_at1;
        int done_at2;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_sclk",     32'(sclk),      32'h0);
        check("rst_sout",     32'(sout),      32'h0);
        check("rst_rck",      32'(rck),       32'h0);
        check("rst_busy",     32'(busy),      32'h0);
        check("rst_done",     32'(done),      32'h0);
        check("rst_chain_ok", 32'(chain_ok),  32'h0);
        check("rst_err",      32'(err_count), 32'h0);
        check("rst_readback", 32'(readback),  32'h0);
        check("rst_first",    32'(first_err), 32'hF);
        reset_n = 1'b1;

        // ---------------- first frame after reset: FFFF ----------------
        run_frame(16'hFFFF, lat, rcks);
        check("f1_latency",  32'(lat),         32'd35);
        check("f1_rck_len",  32'(rcks),        32'd2);
        check("f1_latch",    32'(chain_latch), 32'hFFFF);
        check("f1_chain_ok", 32'(chain_ok),    32'h0);
        check("f1_err",      32'(err_count),   32'h0);
        check("f1_first",    32'(first_err),   32'hF);
        check("f1_readback", 32'(readback),    32'h0000);
        check("f1_idle_sout", 32'(sout),       32'h0);
        check("f1_idle_busy", 32'(busy),       32'h0);

        // ---------------- two frames A55A then 1234 ----------------
        do_reset();
        run_frame(16'hA55A, lat, rcks);
        check("a_latency",   32'(lat),         32'd35);
        check("a_readback",  32'(readback),    32'hFFFF);
        check("a_chain_ok",  32'(chain_ok),    32'h0);
        run_frame(16'h1234, lat, rcks);
        check("b_latency",   32'(lat),         32'd35);
        check("b_readback",  32'(readback),    32'hA55A);
        check("b_chain_ok",  32'(chain_ok),    32'h1);
        check("b_err",       32'(err_count),   32'h0);
        check("b_first",     32'(first_err),   32'hF);
        check("b_latch",     32'(chain_latch), 32'h1234);
        repeat (5) @(negedge clk);
        check("idle_readback", 32'(readback),  32'hA55A);
        check("idle_chain_ok", 32'(chain_ok),  32'h1);
        check("idle_sclk",     32'(sclk),      32'h0);

        // ---------------- chain output stuck low ----------------
        do_reset();
        stuck_low = 1'b1;
        run_frame(16'h00F0, lat, rcks);
        check("s1_err",      32'(err_count),   32'h0);
        check("s1_first",    32'(first_err),   32'hF);
        run_frame(16'h0000, lat, rcks);
        check("s2_readback", 32'(readback),    32'h0000);
        check("s2_err",      32'(err_count),   32'd4);
        check("s2_first",    32'(first_err),   32'd7);
        check("s2_chain_ok", 32'(chain_ok),    32'h0);
        stuck_low = 1'b0;

        // ---------------- start while busy, in DONE, then in IDLE ----------------
        do_reset();
        @(negedge clk);
        done_base = done_pulses;
        done_at1  = 0;
        done_at2  = 0;
        start     = 1'b1;
        expected  = 16'h3C3C;
        for (int k = 1; k <= 75; k++) begin
            @(negedge clk);
            if (done && done_at1 == 0)                   done_at1 = k;
            else if (done && done_at1 != 0 && done_at2 == 0) done_at2 = k;
            if (k == 10) expected = 16'hFFFF;
            if (k == 36) begin
                check("m_latch1",     32'(chain_latch), 32'h3C3C);
                check("m_done_ignore", 32'(busy),       32'h0);
            end
            if (k == 37) check("m_idle_accept", 32'(busy), 32'h1);
            start = (k == 5 || k == 20 || k == 35 || k == 36);
        end
        start = 1'b0;
        check("m_done_at1", 32'(done_at1),               32'd35);
        check("m_done_at2", 32'(done_at2),               32'd71);
        check("m_done_cnt", 32'(done_pulses - done_base), 32'd2);
        check("m_latch2",   32'(chain_latch),            32'hFFFF);

        // ---------------- reset in the middle of a frame ----------------
        do_reset();
        run_frame(16'h5555, lat, rcks);
        run_frame(16'h5555, lat, rcks);
        check("r_pre_chain_ok", 32'(chain_ok), 32'h1);
        @(negedge clk);
        rck_base = rck_cycles;
        start    = 1'b1;
        expected = 16'hAAAA;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("r_sclk",     32'(sclk),      32'h0);
        check("r_sout",     32'(sout),      32'h0);
        check("r_rck",      32'(rck),       32'h0);
        check("r_busy",     32'(busy),      32'h0);
        check("r_done",     32'(done),      32'h0);
        check("r_chain_ok", 32'(chain_ok),  32'h0);
        check("r_err",      32'(err_count), 32'h0);
        check("r_readback", 32'(readback),  32'h0);
        check("r_first",    32'(first_err), 32'hF);
        repeat (2) @(negedge clk);
        check("r_no_rck",   32'(rck_cycles - rck_base), 32'd0);
        reset_n = 1'b1;
        run_frame(16'h0F0F, lat, rcks);
        check("r_next_latency",  32'(lat),         32'd35);
        check("r_next_chain_ok", 32'(chain_ok),    32'h0);
        check("r_next_err",      32'(err_count),   32'h0);
        check("r_next_first",    32'(first_err),   32'hF);
        check("r_next_latch",    32'(chain_latch), 32'h0F0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_tpic_readback
